ecdh_scalar_loader: RTL
=======================

Name: ecdh_scalar_loader

Overview:
- Front-end / back-end wrapper for the EC scalar-multiplication unit.
- Collects a private scalar k and a peer point (Px, Py) from a 32-bit word stream.
- Rejects a zero scalar, pulses start to the scalar unit, captures Qx/Qy on its valid pulse, and streams the shared point back out as 32-bit words.
- Sits between the host bus adapter and the scalar-multiplication core.

Parameters:
- BW_GF, 192, field element width in bits; must be a multiple of WORD_W.
- WORD_W, 32, stream word width.
- NWORD, BW_GF/WORD_W (6), words per field element; derived, not overridable.
- WDT_CYCLES, 1048576, watchdog limit in clk cycles (only used with ECDH_WDT_EN).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts input word.
- in_data  in  WORD_W  input word.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts output word.
- out_data  out  WORD_W  output word.
- out_last  out  1  marks final output word.
- err  out  1  one-cycle error pulse.
- err_code  out  2  01 = zero scalar, 10 = watchdog timeout; held until next err.
- busy  out  1  high in every state except LOAD.
- sc_start  out  1  one-cycle start pulse to scalar unit.
- sc_k  out  BW_GF  scalar to scalar unit.
- sc_px  out  BW_GF  point X to scalar unit.
- sc_py  out  BW_GF  point Y to scalar unit.
- sc_qx  in  BW_GF  result X from scalar unit.
- sc_qy  in  BW_GF  result Y from scalar unit.
- sc_valid  in  1  one-cycle result-valid pulse from scalar unit.

Behaviour:
- Reset values: all outputs 0; in_ready = 0 during reset, 1 in the first cycle after reset release; state LOAD; counters 0; k, px, py, qx, qy registers 0.
- States: LOAD, CHECK, START, WAIT, SEND.
- LOAD:
  - in_ready = 1. A word transfers on in_valid & in_ready.
  - Word order: k, then Px, then Py; each element most-significant word first; 3*NWORD = 18 words total.
  - A 5-bit word counter counts 0..17. On the 18th handshake go to CHECK with in_ready = 0 the next cycle.
- CHECK (1 cycle):
  - If k == 0: err = 1, err_code = 01, return to LOAD. The scalar unit is never started on k = 0.
  - Else go to START.
- START (1 cycle): sc_start = 1, then WAIT.
- sc_k / sc_px / sc_py are driven directly from the load registers. They stay stable from CHECK through WAIT and change only during LOAD.
- WAIT:
  - Ignore in_valid.
  - On the sc_valid pulse, capture sc_qx/sc_qy into internal registers in that same cycle, then go to SEND. The scalar unit's outputs are not relied on afterwards.
  - sc_valid seen in any state other than WAIT is ignored.
- SEND:
  - out_valid = 1. Word order: Qx MSW first, then Qy; 2*NWORD = 12 words.
  - out_data and out_last are stable while out_valid & ~out_ready (backpressure holds the word).
  - out_last = 1 only on word 11.
  - On the handshake of word 11: go to LOAD, out_valid = 0 the next cycle.
- Latency:
  - Last input handshake to sc_start = 2 cycles (CHECK, START).
  - sc_valid to first out_valid = 1 cycle.
- in_ready and out_valid are never high in the same cycle. No combinational path from in_valid or out_ready to any output.
- Reset asserted mid-operation: immediate return to LOAD; partial words discarded; out_valid and sc_start drop asynchronously.
- busy is registered from the state: 0 in LOAD, 1 otherwise.

Optional Feature:
- Macro ECDH_WDT_EN.
- Defined:
  - A 21-bit cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches WDT_CYCLES without sc_valid: err = 1, err_code = 10, return to LOAD, no output words.
  - sc_valid arriving in the same cycle as the timeout wins: result is captured and no error is raised.
- Undefined: no counter; WAIT waits indefinitely; err_code 10 is never produced.

Test Plan:
- Scalar-unit stub returns qx = 0x11..11, qy = 0x22..22 twenty cycles after sc_start. Load k = 1, Px = 0xA0..A0, Py = 0xB0..B0 -> sc_start exactly 2 cycles after the 18th handshake; sc_k = 1; 12 output words 0x11111111 x6 then 0x22222222 x6; out_last on word 12 only.
- Load k = 0 -> err pulse with err_code = 01 the cycle after the 18th handshake; sc_start never asserted; in_ready = 1 again the following cycle.
- During SEND, hold out_ready = 0 for 5 cycles at word 3, then toggle every cycle -> no dropped or duplicated words; out_data stable while stalled.
- Stub changes sc_qx to 0xFF..FF one cycle after sc_valid -> output still 0x11..11 (captured value).
- Assert rst_n low for 1 cycle after 9 input words, then load a full valid frame -> only the second frame's values reach sc_k/sc_px/sc_py; one sc_start.
- With ECDH_WDT_EN and WDT_CYCLES = 64, stub never responds -> err with err_code = 10 exactly 64 cycles after entering WAIT; no out_valid. Without the macro, busy stays 1.

Source files
------------

// File: rtl/ecdh_scalar_loader.sv
// Stream front/back end for the EC scalar-multiplication unit: loads k, Px, Py
// as 32-bit words, starts the unit, then streams Qx/Qy back. ECDH_WDT_EN adds a WAIT watchdog.
module ecdh_scalar_loader #(
  parameter int BW_GF      = 192,
  parameter int WORD_W     = 32,
  parameter int WDT_CYCLES = 1048576
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              busy,
  output logic              sc_start,
  output logic [BW_GF-1:0]  sc_k,
  output logic [BW_GF-1:0]  sc_px,
  output logic [BW_GF-1:0]  sc_py,
  input  logic [BW_GF-1:0]  sc_qx,
  input  logic [BW_GF-1:0]  sc_qy,
  input  logic              sc_valid
);
  localparam int NWORD = BW_GF / WORD_W;
  localparam int LDW   = 3 * BW_GF;
  localparam int QW    = 2 * BW_GF;
  localparam logic [4:0] LD_LAST = 5'(3 * NWORD - 1);
  localparam logic [4:0] Q_LAST  = 5'(2 * NWORD - 1);

  typedef enum logic [2:0] {S_LOAD, S_CHECK, S_START, S_WAIT, S_SEND} state_t;

  state_t            r_state;
  logic [4:0]        r_cnt;
  logic [LDW-1:0]    r_ld;
  logic [QW-1:0]     r_q;
  logic              r_in_ready, r_out_valid, r_out_last, r_err, r_busy, r_sc_start;
  logic [1:0]        r_err_code;
  logic              w_in_hs, w_out_hs;
  logic [BW_GF-1:0]  w_k_nxt;

  assign w_in_hs  = in_valid & r_in_ready;
  assign w_out_hs = out_ready & r_out_valid;
  // k as it will look once the word being accepted has been shifted in
  assign w_k_nxt  = r_ld[LDW-WORD_W-1 -: BW_GF];

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_q[QW-1 -: WORD_W];
  assign out_last  = r_out_last;
  assign err       = r_err;
  assign err_code  = r_err_code;
  assign busy      = r_busy;
  assign sc_start  = r_sc_start;
  assign sc_k      = r_ld[LDW-1 -: BW_GF];
  assign sc_px     = r_ld[QW-1 -: BW_GF];
  assign sc_py     = r_ld[BW_GF-1:0];

`ifdef ECDH_WDT_EN
  localparam logic [20:0] WDT_LIM = 21'(WDT_CYCLES - 1);
  logic [20:0] r_wdt;
`else
  logic [31:0] w_unused_wdt;
  assign w_unused_wdt = 32'(WDT_CYCLES);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_LOAD;
      r_cnt       <= '0;
      r_ld        <= '0;
      r_q         <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= 2'b00;
      r_busy      <= 1'b0;
      r_sc_start  <= 1'b0;
`ifdef ECDH_WDT_EN
      r_wdt       <= '0;
`endif
    end else begin
      r_err      <= 1'b0;
      r_sc_start <= 1'b0;
      case (r_state)
        S_LOAD: begin
          r_in_ready <= 1'b1;
          if (w_in_hs) begin
            r_ld <= {r_ld[LDW-WORD_W-1:0], in_data};
            if (r_cnt == LD_LAST) begin
              r_cnt      <= '0;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
              r_state    <= S_CHECK;
              // flag a zero scalar now so err lands in the CHECK cycle
              if (w_k_nxt == '0) begin
                r_err      <= 1'b1;
                r_err_code <= 2'b01;
              end
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
        end
        S_CHECK: begin
          if (sc_k == '0) begin
            r_state    <= S_LOAD;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
          end else begin
            r_state    <= S_START;
            r_sc_start <= 1'b1;
          end
        end
        S_START: begin
          r_state <= S_WAIT;
`ifdef ECDH_WDT_EN
          r_wdt   <= '0;
`endif
        end
        S_WAIT: begin
          if (sc_valid) begin
            r_q         <= {sc_qx, sc_qy};
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
            r_cnt       <= '0;
            r_state     <= S_SEND;
          end
`ifdef ECDH_WDT_EN
          else if (r_wdt == WDT_LIM) begin
            r_err      <= 1'b1;
            r_err_code <= 2'b10;
            r_state    <= S_LOAD;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
          end else begin
            r_wdt <= r_wdt + 21'd1;
          end
`endif
        end
        S_SEND: begin
          if (w_out_hs) begin
            r_q <= {r_q[QW-WORD_W-1:0], {WORD_W{1'b0}}};
            if (r_cnt == Q_LAST) begin
              r_cnt       <= '0;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_in_ready  <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= S_LOAD;
            end else begin
              r_cnt      <= r_cnt + 5'd1;
              r_out_last <= (r_cnt == Q_LAST - 5'd1);
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end
endmodule
